// File: rtl/wc_stream_engine_if.sv
// Handshake bundle for wc_stream_engine: filter load, input tile and output result channels.
interface wc_stream_engine_if #(
  parameter int DW = 10,
  parameter int WW = 10,
  parameter int OW = 10
);
  logic              w_load;
  logic [4*WW-1:0]   W;
  logic              w_ready;
  logic              in_valid;
  logic              in_ready;
  logic [6*DW-1:0]   D;
  logic              out_valid;
  logic              out_ready;
  logic [3*OW-1:0]   Z;
  logic              ovf;
  logic [15:0]       tile_cnt;

  modport master (
    output w_load, W, in_valid, D, out_ready,
    input  w_ready, in_ready, out_valid, Z, ovf, tile_cnt
  );

  modport slave (
    input  w_load, W, in_valid, D, out_ready,
    output w_ready, in_ready, out_valid, Z, ovf, tile_cnt
  );
endinterface

// File: rtl/wc_stream_engine.sv
// Streaming Winograd F(3,4) correlation engine: Z[i] = sum_k D[i+k]*W[k].
// Interpolation points 0, 1, -1, 2, -2, inf. The filter transform is pre-scaled by 24
// to keep every coefficient integral; the exact division by 24 happens in S4.
module wc_stream_engine #(
  parameter int DW  = 10,
  parameter int WW  = 10,
  parameter int OW  = 10,
  parameter bit SAT = 1'b1
) (
  input logic              clk,
  input logic              rst,
  wc_stream_engine_if.slave s_if
);

  localparam int IW = DW + WW + 14;
  typedef logic signed [IW-1:0] iw_t;
  localparam iw_t SCALE = iw_t'(24);
  localparam iw_t ZMAX  = (iw_t'(1) <<< (OW-1)) - iw_t'(1);
  localparam iw_t ZMIN  = -(iw_t'(1) <<< (OW-1));

  // v_q[0] is the tile capture register; v_q[1..4] are S1..S4 (v_q[4] = out_valid).
  logic [4:0]           v_q;
  logic                 stall, load, take, wrdy;
  logic signed [DW-1:0] d_q [6];
  iw_t                  b_q [6], b_d [6];
  iw_t                  g_q [6], g_d [6];
  iw_t                  m_q [6], m_d [6];
  iw_t                  y_q [3], y_d [3];
  logic signed [OW-1:0] z_q [3], z_d [3];
  logic                 tovf_q, tovf_d, ovf_q;
  logic [15:0]          cnt_q;

  // Handshake: global stall, load priority over a simultaneous tile.
  always_comb begin
    wrdy          = ~|v_q;
    stall         = v_q[4] & ~s_if.out_ready;
    load          = s_if.w_load & wrdy;
    take          = s_if.in_valid & ~stall & ~load;
    s_if.w_ready  = wrdy;
    s_if.in_ready = ~stall & ~load;
  end

  assign s_if.out_valid = v_q[4];
  assign s_if.Z         = {z_q[0], z_q[1], z_q[2]};
  assign s_if.ovf       = ovf_q;
  assign s_if.tile_cnt  = cnt_q;

  // Filter transform 24*G*g, captured on the load edge.
  always_comb begin
    iw_t w [4];
    iw_t sp, sn;
    for (int unsigned k = 0; k < 4; k++) begin
      w[k] = iw_t'(signed'(s_if.W[(3-k)*WW +: WW]));
    end
    sp     = w[0] + w[1] + w[2] + w[3];
    sn     = w[0] - w[1] + w[2] - w[3];
    g_d[0] = (w[0] <<< 2) + (w[0] <<< 1);
    g_d[1] = -(sp <<< 2);
    g_d[2] = -(sn <<< 2);
    g_d[3] = w[0] + (w[1] <<< 1) + (w[2] <<< 2) + (w[3] <<< 3);
    g_d[4] = w[0] - (w[1] <<< 1) + (w[2] <<< 2) - (w[3] <<< 3);
    g_d[5] = (w[3] <<< 4) + (w[3] <<< 3);
  end

  // S1 input transform B^T*d.
  always_comb begin
    iw_t x [6];
    for (int unsigned k = 0; k < 6; k++) begin
      x[k] = iw_t'(d_q[k]);
    end
    b_d[0] = (x[0] <<< 2) - (x[2] <<< 2) - x[2] + x[4];
    b_d[1] = -(x[1] <<< 2) - (x[2] <<< 2) + x[3] + x[4];
    b_d[2] = (x[1] <<< 2) - (x[2] <<< 2) - x[3] + x[4];
    b_d[3] = -(x[1] <<< 1) - x[2] + (x[3] <<< 1) + x[4];
    b_d[4] = (x[1] <<< 1) - x[2] - (x[3] <<< 1) + x[4];
    b_d[5] = (x[1] <<< 2) - (x[3] <<< 2) - x[3] + x[5];
  end

  // S2 element-wise products, the only six multipliers.
  always_comb begin
    for (int unsigned k = 0; k < 6; k++) begin
      m_d[k] = b_q[k] * g_q[k];
    end
  end

  // S3 output transform A^T*m (still scaled by 24).
  always_comb begin
    y_d[0] = m_q[0] + m_q[1] + m_q[2] + m_q[3] + m_q[4];
    y_d[1] = m_q[1] - m_q[2] + (m_q[3] <<< 1) - (m_q[4] <<< 1);
    y_d[2] = m_q[1] + m_q[2] + (m_q[3] <<< 2) + (m_q[4] <<< 2) + m_q[5];
  end

  // S4 exact rescale, range check and saturate/wrap.
  always_comb begin
    iw_t  q;
    logic hi, lo;
    tovf_d = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      q      = y_q[k] / SCALE;
      hi     = (q > ZMAX);
      lo     = (q < ZMIN);
      z_d[k] = q[OW-1:0];
      if (hi || lo) tovf_d = 1'b1;
      if (SAT) begin
        if (hi)      z_d[k] = ZMAX[OW-1:0];
        else if (lo) z_d[k] = ZMIN[OW-1:0];
      end
    end
  end

  // Transformed filter register, rewritten only while the pipeline is drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       g_q <= '{default: '0};
    else if (load) g_q <= g_d;
  end

  // Pipeline valids and datapath; every stage holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      d_q    <= '{default: '0};
      b_q    <= '{default: '0};
      m_q    <= '{default: '0};
      y_q    <= '{default: '0};
      z_q    <= '{default: '0};
      tovf_q <= 1'b0;
    end else if (!stall) begin
      v_q <= {v_q[3:0], take};
      for (int unsigned k = 0; k < 6; k++) begin
        d_q[k] <= signed'(s_if.D[(5-k)*DW +: DW]);
      end
      b_q    <= b_d;
      m_q    <= m_d;
      y_q    <= y_d;
      z_q    <= z_d;
      tovf_q <= tovf_d;
    end
  end

  // Output handshake bookkeeping: tile counter and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (v_q[4] && s_if.out_ready) begin
      cnt_q <= cnt_q + 16'd1;
      ovf_q <= ovf_q | tovf_q;
    end
  end

endmodule

// File: tb/tb_wc_stream_engine.sv
// Directed bench for wc_stream_engine: vector table plus stall, load and reset sequences.
module tb_wc_stream_engine;
  localparam int DW = 10;
  localparam int WW = 10;
  localparam int OW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wc_stream_engine_if #(.DW(DW), .WW(WW), .OW(OW)) bus ();

  wc_stream_engine #(.DW(DW), .WW(WW), .OW(OW), .SAT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .s_if(bus)
  );

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;
  logic [3*OW-1:0] exp_q [$];

  typedef struct {
    int d [6];
    int z [3];
    bit ovf;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  function automatic logic [6*DW-1:0] packd(input int a0, a1, a2, a3, a4, a5);
    return {DW'(a0), DW'(a1), DW'(a2), DW'(a3), DW'(a4), DW'(a5)};
  endfunction

  function automatic logic [4*WW-1:0] packw(input int a0, a1, a2, a3);
    return {WW'(a0), WW'(a1), WW'(a2), WW'(a3)};
  endfunction

  function automatic logic [3*OW-1:0] packz(input int a0, a1, a2);
    return {OW'(a0), OW'(a1), OW'(a2)};
  endfunction

  function automatic logic [31:0] zel(input int unsigned i);
    logic signed [OW-1:0] e;
    e = bus.Z[(2-i)*OW +: OW];
    return 32'(e);
  endfunction

  task automatic setv(input int i, input int a0, a1, a2, a3, a4, a5,
                      input int z0, z1, z2, input bit o);
    vt[i].d = '{a0, a1, a2, a3, a4, a5};
    vt[i].z = '{z0, z1, z2};
    vt[i].ovf = o;
  endtask

  task automatic load_w(input logic [4*WW-1:0] w);
    int n;
    @(negedge clk);
    bus.w_load = 1'b1;
    bus.W = w;
    #1;
    n = 0;
    while (!bus.w_ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("load w_ready", 32'(bus.w_ready), 1);
    chk("load in_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.w_load = 1'b0;
  endtask

  // Single isolated tile: acceptance, 4-edge latency, value, bubble after handshake.
  task automatic apply(input logic [6*DW-1:0] d, input int z0, z1, z2, input string tag);
    int lat;
    @(negedge clk);
    bus.D = d;
    bus.in_valid = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " Z0"}, zel(0), z0);
    chk({tag, " Z1"}, zel(1), z1);
    chk({tag, " Z2"}, zel(2), z2);
    @(posedge clk); #1;
    chk({tag, " valid cleared"}, 32'(bus.out_valid), 0);
  endtask

  task automatic push_tile(input logic [6*DW-1:0] d, input logic [3*OW-1:0] z);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.D = d;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("push in_ready", 32'(bus.in_ready), 1);
    if (bus.in_ready) exp_q.push_back(z);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk); n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Stream monitor: in-order scoreboard and hold-while-stalled checks.
  initial begin : monitor
    logic            prev_stall;
    logic [3*OW-1:0] prev_z;
    prev_stall = 1'b0;
    prev_z = '0;
    forever begin
      @(negedge clk); #2;
      if (rst || !mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold out_valid", 32'(bus.out_valid), 1);
          chk("hold Z", 32'(bus.Z), 32'(prev_z));
        end
        if (bus.out_valid && !bus.out_ready) chk("in_ready in stall", 32'(bus.in_ready), 0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious output: got Z=0x%0h with no tile outstanding", bus.Z);
          end else begin
            chk("stream Z", 32'(bus.Z), 32'(exp_q.pop_front()));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_z = bus.Z;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int sent, fo, n;
    bus.w_load = 1'b0;
    bus.W = '0;
    bus.in_valid = 1'b0;
    bus.D = '0;
    bus.out_ready = 1'b1;

    setv(0,   1,   1,  1,    1,   1,   1,   10,  10,   10, 1'b0);
    setv(1,   1,   2,  3,    4,   5,   6,   30,  40,   50, 1'b0);
    setv(2,   2, -10,  3,    4, -13, -18,    7, -44, -100, 1'b0);
    setv(3,   0,   0,  0,    0,   0,   0,    0,   0,    0, 1'b0);
    setv(4,  -1,  -1, -1,   -1,  -1,  -1,  -10, -10,  -10, 1'b0);
    setv(5, 100,   0,  0,    0,   0,   0,  100,   0,    0, 1'b0);
    setv(6,   0,   0,  0,    0,   0,  50,    0,   0,  200, 1'b0);
    setv(7,   0,   0,  0, -128,   0,   0, -512, -384, -256, 1'b0);
    setv(8, 511,   0,  0,    0,   0,   0,  511,   0,    0, 1'b0);
    setv(9,   0,   0,  0,  128,   0,   0,  511, 384,  256, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset Z", 32'(bus.Z), 0);
    chk("reset ovf", 32'(bus.ovf), 0);
    chk("reset tile_cnt", 32'(bus.tile_cnt), 0);
    chk("reset w_ready", 32'(bus.w_ready), 1);
    chk("reset in_ready", 32'(bus.in_ready), 1);
    rst = 1'b0;

    // Vector table with W = [1,2,3,4]
    load_w(packw(1, 2, 3, 4));
    for (int i = 0; i < 10; i++) begin
      apply(packd(vt[i].d[0], vt[i].d[1], vt[i].d[2], vt[i].d[3], vt[i].d[4], vt[i].d[5]),
            vt[i].z[0], vt[i].z[1], vt[i].z[2], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d ovf", i), 32'(bus.ovf), 32'(vt[i].ovf));
    end
    chk("tile_cnt after table", 32'(bus.tile_cnt), 10);

    // Full-scale saturation
    load_w(packw(511, 511, 511, 511));
    apply(packd(511, 511, 511, 511, 511, 511), 511, 511, 511, "sat+");
    apply(packd(-512, -512, -512, -512, -512, -512), -512, -512, -512, "sat-");
    chk("sat ovf", 32'(bus.ovf), 1);
    chk("tile_cnt after sat", 32'(bus.tile_cnt), 12);

    // 8 back-to-back tiles with a 4-cycle output stall
    load_w(packw(1, 2, 3, 4));
    mon_en = 1'b1;
    sent = 0;
    fo = -1;
    for (int cyc = 0; cyc < 60 && (sent < 8 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      if (fo < 0 && bus.out_valid) fo = cyc;
      bus.out_ready = !(fo >= 0 && cyc - fo >= 2 && cyc - fo <= 5);
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.D = packd(sent + 1, 2 * (sent + 1), 3 * (sent + 1), 4 * (sent + 1),
                      5 * (sent + 1), 6 * (sent + 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(packz(30 * (sent + 1), 40 * (sent + 1), 50 * (sent + 1)));
        sent++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("burst sent", sent, 8);
    chk("burst drained", exp_q.size(), 0);
    chk("tile_cnt after burst", 32'(bus.tile_cnt), 20);

    // Filter load requested while tiles are in flight
    for (int t = 0; t < 3; t++) push_tile(packd(1, 2, 3, 4, 5, 6), packz(30, 40, 50));
    @(negedge clk);
    bus.w_load = 1'b1;
    bus.W = packw(0, 0, 0, 1);
    #1;
    chk("w_ready busy", 32'(bus.w_ready), 0);
    n = 0;
    while (!bus.w_ready && n < 30) begin
      @(negedge clk); #1; n++;
    end
    chk("w_ready drained", 32'(bus.w_ready), 1);
    bus.in_valid = 1'b1;
    bus.D = packd(1, 2, 3, 4, 5, 6);
    #1;
    chk("in_ready at load", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.w_load = 1'b0;
    @(negedge clk); #1;
    chk("in_ready after load", 32'(bus.in_ready), 1);
    if (bus.in_ready) exp_q.push_back(packz(4, 5, 6));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drain("load drain");
    chk("tile_cnt after load", 32'(bus.tile_cnt), 24);

    // Reset with 3 tiles in flight
    for (int t = 0; t < 3; t++) push_tile(packd(1, 2, 3, 4, 5, 6), packz(4, 5, 6));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 0);
    chk("midrst Z", 32'(bus.Z), 0);
    chk("midrst tile_cnt", 32'(bus.tile_cnt), 0);
    chk("midrst ovf", 32'(bus.ovf), 0);
    chk("midrst w_ready", 32'(bus.w_ready), 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    push_tile(packd(1, 2, 3, 4, 5, 6), packz(0, 0, 0));
    wait_drain("post-reset drain");
    chk("post-reset tile_cnt", 32'(bus.tile_cnt), 1);
    chk("post-reset ovf", 32'(bus.ovf), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
